// File: rtl/mfp_ahb_lite_pic.sv
// mfp_ahb_lite_pic: AHB-Lite programmable-priority external interrupt controller for the MIPS32 EIC port
module mfp_ahb_lite_pic #(
  parameter int CHANNELS = 16,
  parameter int PRIO_W   = 4
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  input  logic [31:0]         HADDR,
  input  logic [1:0]          HTRANS,
  input  logic                HWRITE,
  input  logic                HSEL,
  input  logic                HREADY,
  input  logic [31:0]         HWDATA,
  input  logic [2:0]          HSIZE,
  input  logic [2:0]          HBURST,
  input  logic [3:0]          HPROT,
  input  logic                HMASTLOCK,
  output logic [31:0]         HRDATA,
  output logic                HREADYOUT,
  output logic                HRESP,
  input  logic [CHANNELS-1:0] EIC_input,
  output logic [7:0]          EIC_Interrupt,
  output logic [5:0]          EIC_Vector,
  output logic [16:0]         EIC_Offset,
  output logic [3:0]          EIC_ShadowSet,
  output logic                EIC_Present,
  input  logic                EIC_IAck,
  input  logic [5:0]          EIC_IVN,
  input  logic [7:0]          EIC_IPL,
  input  logic [16:0]         EIC_ION
);
  localparam logic [5:0] A_MASK = 6'h00, A_PEND = 6'h01, A_SENSE0 = 6'h02, A_SENSE1 = 6'h03;
  localparam logic [5:0] A_RAW = 6'h04, A_STATUS = 6'h05, A_SWINT = 6'h06, A_PRIO = 6'h10;
  logic [5:0]          r_addr;
  logic                r_wr;
  logic [CHANNELS-1:0] r_mask, r_sync1, r_sync2, r_prev, r_pend_e;
  logic [1:0]          r_sense [CHANNELS];
  logic [PRIO_W-1:0]   r_prio [CHANNELS];
  logic [7:0]          r_ipl;
  logic [5:0]          r_vec;
  logic                r_active;
  logic                w_xfer;
  logic [CHANNELS-1:0] w_set, w_clr, w_pend, w_cand;
  logic [PRIO_W-1:0]   w_best_p;
  logic [5:0]          w_best_i;
  logic                w_any;
  logic [63:0]         w_sense_all;
  logic [31:0]         w_prio_rd;
  logic                w_unused;
  assign w_xfer        = HSEL & HREADY & HTRANS[1];
  assign w_unused      = ^{HADDR[31:8], HADDR[1:0], HTRANS[0], HSIZE, HBURST, HPROT, HMASTLOCK, EIC_IPL, EIC_ION};
  assign HREADYOUT     = 1'b1;
  assign HRESP         = 1'b0;
  assign EIC_Offset    = '0;
  assign EIC_ShadowSet = '0;
  assign EIC_Present   = 1'b1;
  assign EIC_Interrupt = r_ipl;
  assign EIC_Vector    = r_vec;
  // Capture the address phase of qualified transfers; a write commits in the following cycle
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      r_addr <= '0;
      r_wr   <= 1'b0;
    end else begin
      r_wr <= w_xfer & HWRITE;
      if (w_xfer) r_addr <= HADDR[7:2];
    end
  // Two-flop synchroniser plus one flop of edge history, kept running in every sense mode
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= EIC_input;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  // Per-channel set/clear terms; level channels expose the synchronised input directly
  always_comb begin
    w_set  = '0;
    w_clr  = '0;
    w_pend = '0;
    w_cand = '0;
    for (int n = 0; n < CHANNELS; n++) begin
      w_set[n]  = (r_sense[n][0] & r_sync2[n] & ~r_prev[n]) | (r_sense[n][1] & ~r_sync2[n] & r_prev[n]) |
                  ((r_sense[n] != 2'b00) & r_wr & (r_addr == A_SWINT) & HWDATA[n]);
      w_clr[n]  = (r_wr & (r_addr == A_PEND) & HWDATA[n]) | (EIC_IAck & (EIC_IVN == 6'(n)));
      w_pend[n] = (r_sense[n] == 2'b00) ? r_sync2[n] : r_pend_e[n];
      w_cand[n] = w_pend[n] & r_mask[n] & (r_prio[n] != '0);
    end
  end
  // Programmable registers and edge-pending flags; a set beats a clear in the same cycle
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      r_mask   <= '0;
      r_pend_e <= '0;
      r_sense  <= '{default: '0};
      r_prio   <= '{default: '0};
    end else begin
      r_pend_e <= w_set | (r_pend_e & ~w_clr);
      if (r_wr && r_addr == A_MASK) r_mask <= HWDATA[CHANNELS-1:0];
      for (int n = 0; n < CHANNELS; n++) begin
        if (r_wr && r_addr == ((n < 16) ? A_SENSE0 : A_SENSE1)) r_sense[n] <= HWDATA[2*(n%16) +: 2];
        if (r_wr && r_addr == A_PRIO + 6'(n)) r_prio[n] <= HWDATA[PRIO_W-1:0];
      end
    end
  // Highest priority wins; strict compare keeps the lowest index on ties
  always_comb begin
    w_best_p = '0;
    w_best_i = '0;
    w_any    = 1'b0;
    for (int n = 0; n < CHANNELS; n++)
      if (w_cand[n] && r_prio[n] > w_best_p) begin
        w_best_p = r_prio[n];
        w_best_i = 6'(n);
        w_any    = 1'b1;
      end
  end
  // Register the arbitration result every cycle toward the CPU
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      r_ipl    <= '0;
      r_vec    <= '0;
      r_active <= 1'b0;
    end else begin
      r_ipl    <= 8'(w_best_p);
      r_vec    <= w_best_i;
      r_active <= w_any;
    end
  // Read data mux driven by the registered address; unmapped offsets and SWINT read zero
  always_comb begin
    w_sense_all = '0;
    w_prio_rd   = '0;
    for (int n = 0; n < CHANNELS; n++) begin
      w_sense_all[2*n +: 2] = r_sense[n];
      if (r_addr == A_PRIO + 6'(n)) w_prio_rd = 32'(r_prio[n]);
    end
    case (r_addr)
      A_MASK:   HRDATA = 32'(r_mask);
      A_PEND:   HRDATA = 32'(w_pend);
      A_SENSE0: HRDATA = w_sense_all[31:0];
      A_SENSE1: HRDATA = w_sense_all[63:32];
      A_RAW:    HRDATA = 32'(r_sync2);
      A_STATUS: HRDATA = 32'({r_active, 2'b00, r_vec});
      default:  HRDATA = w_prio_rd;
    endcase
  end
endmodule
